// File: rtl/fifo_wr_ptr_gen_if.sv
// rtl/fifo_wr_ptr_gen_if.sv - write-side pointer/flag bundle for the dual-clock FIFO
interface fifo_wr_ptr_gen_if #(
    parameter int A_LENGTH = 3
);
    logic                  wr_en;
    logic                  clr_ovf;
    logic [A_LENGTH-1:0]   rd_ptr_gray_sync;
    logic [A_LENGTH-1:0]   wr_ptr_gray;
    logic [A_LENGTH-2:0]   wr_addr;
    logic                  mem_we;
    logic                  full;
    logic                  almost_full;
    logic [A_LENGTH-1:0]   wr_count;
    logic                  overflow;

    // Producer / testbench side
    modport master (
        output wr_en, clr_ovf, rd_ptr_gray_sync,
        input  wr_ptr_gray, wr_addr, mem_we, full, almost_full, wr_count, overflow
    );

    // Pointer generator side
    modport slave (
        input  wr_en, clr_ovf, rd_ptr_gray_sync,
        output wr_ptr_gray, wr_addr, mem_we, full, almost_full, wr_count, overflow
    );
endinterface

// File: rtl/fifo_wr_ptr_gen.sv
// rtl/fifo_wr_ptr_gen.sv - write pointer, Gray publish and full/occupancy flags
module fifo_wr_ptr_gen #(
    parameter int A_LENGTH  = 3,
    parameter int AF_MARGIN = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    fifo_wr_ptr_gen_if.slave  bus
);
    localparam int DEPTH = 2 ** (A_LENGTH - 1);
    localparam logic [A_LENGTH-1:0] DEPTH_V   = A_LENGTH'(DEPTH);
    localparam logic [A_LENGTH-1:0] AF_THRESH = A_LENGTH'(DEPTH - AF_MARGIN);

    logic [A_LENGTH-1:0] wr_bin;
    logic [A_LENGTH-1:0] wr_bin_next;
    logic [A_LENGTH-1:0] rd_bin;
    logic [A_LENGTH-1:0] count_next;
    logic [A_LENGTH-1:0] gray_q;
    logic [A_LENGTH-1:0] count_q;
    logic                full_q;
    logic                af_q;
    logic                ovf_q;
    logic                accept;

    // A write is taken only when there is room and the block is out of reset
    assign accept      = bus.wr_en & ~full_q & ~reset;
    assign wr_bin_next = wr_bin + {{(A_LENGTH-1){1'b0}}, accept};
    assign count_next  = wr_bin_next - rd_bin;

    // Gray-to-binary of the synchronized read pointer: running XOR from the MSB down
    always_comb begin
        rd_bin = '0;
        rd_bin[A_LENGTH-1] = bus.rd_ptr_gray_sync[A_LENGTH-1];
        for (int i = A_LENGTH - 2; i >= 0; i--) begin
            rd_bin[i] = rd_bin[i+1] ^ bus.rd_ptr_gray_sync[i];
        end
    end

    // Pointer, published Gray pointer and flags all update together from the next-state values
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_bin  <= '0;
            gray_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_next;
            gray_q  <= wr_bin_next ^ (wr_bin_next >> 1);
            count_q <= count_next;
            full_q  <= (count_next == DEPTH_V);
            af_q    <= (count_next >= AF_THRESH);
            // set dominates clear so a rejected write is never lost
            ovf_q   <= (bus.wr_en & full_q) | (ovf_q & ~bus.clr_ovf);
        end
    end

    assign bus.mem_we      = accept;
    assign bus.wr_addr     = wr_bin[A_LENGTH-2:0];
    assign bus.wr_ptr_gray = gray_q;
    assign bus.wr_count    = count_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule
